// File: rtl/seg7_bcd_scan_counter_if.sv
// Signal bundle for seg7_bcd_scan_counter.
// The master side drives the count controls and display decimal points.
// The slave side (the counter) returns the BCD value, the wrap pulse and the display pins.
interface seg7_bcd_scan_counter_if #(
    parameter int DIGITS = 6
);
    logic                  en;
    logic                  up_dn;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [DIGITS-1:0]     dp_mask;
    logic [4*DIGITS-1:0]   count;
    logic                  wrap;
    logic [DIGITS-1:0]     sel_out;
    logic [7:0]            dig_out;

    modport master (
        output en, up_dn, load, load_val, dp_mask,
        input  count, wrap, sel_out, dig_out
    );

    modport slave (
        input  en, up_dn, load, load_val, dp_mask,
        output count, wrap, sel_out, dig_out
    );
endinterface

// File: rtl/seg7_bcd_scan_counter.sv
// N-digit BCD up/down counter with a tick prescaler and a time-multiplexed
// common-anode 7-segment scan driver (active-low digit selects and segments).
// The count steps once every TICK_DIV enabled clocks. Each digit is lit for
// SCAN_DIV clocks in turn.
// Optional macro SEG7_LZB_EN: blank leading zero digits (digit 0 is never blanked).
module seg7_bcd_scan_counter #(
    parameter int DIGITS   = 6,
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 50_000
) (
    input  logic                        clk,
    input  logic                        reset,
    seg7_bcd_scan_counter_if.slave      bus
);

    localparam int CW = 4 * DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam int IW = $clog2(DIGITS + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    // Clamp each nibble of a load value to a legal BCD digit.
    function automatic logic [CW-1:0] bcd_saturate(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    // One BCD step up (ripple carry) or down (ripple borrow) across all digits.
    function automatic logic [CW-1:0] bcd_step(input logic [CW-1:0] v, input logic up);
        logic [CW-1:0] r;
        logic          c;
        logic [3:0]    n;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            n = v[4*i +: 4];
            if (c) begin
                if (up) begin
                    if (n >= 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = n + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (n == 4'd0) begin
                        r[4*i +: 4] = 4'd9;
                    end else begin
                        r[4*i +: 4] = n - 4'd1;
                        c = 1'b0;
                    end
                end
            end else begin
                r[4*i +: 4] = n;
            end
        end
        return r;
    endfunction

    // True when every digit equals the given nibble.
    function automatic logic bcd_all(input logic [CW-1:0] v, input logic [3:0] nib);
        logic r;
        r = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            r = r & (v[4*i +: 4] == nib);
        end
        return r;
    endfunction

    // Active-low segment pattern g..a for one BCD digit. An illegal code is shown blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    logic [PW-1:0]     presc_r;
    logic [CW-1:0]     count_r;
    logic              wrap_r;
    logic [SW-1:0]     scan_cnt_r;
    logic [IW-1:0]     idx_r;
    logic [DIGITS-1:0] sel_out_r;
    logic [7:0]        dig_out_r;

    logic              tick_s;
    logic              roll_s;
    logic              scan_end_s;
    logic [DIGITS-1:0] sel_onehot_s;
    logic [3:0]        nib_s;
    logic              dp_s;
    logic              lz_blank_s;

    // Step strobe, terminal-value detection and scan slot end.
    always_comb begin
        tick_s     = bus.en && (presc_r == PRESC_LAST);
        roll_s     = bus.up_dn ? bcd_all(count_r, 4'd9) : bcd_all(count_r, 4'd0);
        scan_end_s = (scan_cnt_r == SCAN_LAST);
    end

    // One-hot AND-OR select of the nibble and decimal point of the current digit.
    always_comb begin
        sel_onehot_s = DIGITS'(1) << idx_r;
        nib_s        = 4'd0;
        dp_s         = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            nib_s = nib_s | (count_r[4*i +: 4] & {4{sel_onehot_s[i]}});
            dp_s  = dp_s  | (bus.dp_mask[i] & sel_onehot_s[i]);
        end
    end

`ifdef SEG7_LZB_EN
    logic [DIGITS-1:0] blank_s;
    logic              zero_run_s;

    // Mark digits above 0 whose nibble and every higher nibble are zero.
    always_comb begin
        blank_s    = '0;
        zero_run_s = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run_s = zero_run_s & (count_r[4*i +: 4] == 4'd0);
            blank_s[i] = zero_run_s & (i != 0);
        end
        lz_blank_s = |(blank_s & sel_onehot_s);
    end
`else
    assign lz_blank_s = 1'b0;
`endif

    // Prescaler, BCD counter and wrap pulse. A load overrides a tick in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_r <= '0;
            count_r <= '0;
            wrap_r  <= 1'b0;
        end else if (bus.load) begin
            presc_r <= '0;
            count_r <= bcd_saturate(bus.load_val);
            wrap_r  <= 1'b0;
        end else if (tick_s) begin
            presc_r <= '0;
            count_r <= bcd_step(count_r, bus.up_dn);
            wrap_r  <= roll_s;
        end else if (bus.en) begin
            presc_r <= presc_r + PW'(1);
            wrap_r  <= 1'b0;
        end else begin
            wrap_r  <= 1'b0;
        end
    end

    // Free-running scan slot timer and digit index (wraps explicitly at the last digit).
    always_ff @(posedge clk) begin
        if (!reset) begin
            scan_cnt_r <= '0;
            idx_r      <= '0;
        end else if (scan_end_s) begin
            scan_cnt_r <= '0;
            idx_r      <= (idx_r == IDX_LAST) ? '0 : idx_r + IW'(1);
        end else begin
            scan_cnt_r <= scan_cnt_r + SW'(1);
        end
    end

    // Registered display pins, one cycle behind the digit index and count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sel_out_r <= '1;
            dig_out_r <= 8'hFF;
        end else begin
            sel_out_r <= ~sel_onehot_s;
            dig_out_r <= {~dp_s, (lz_blank_s ? 7'h7F : seg_decode(nib_s))};
        end
    end

    assign bus.count   = count_r;
    assign bus.wrap    = wrap_r;
    assign bus.sel_out = sel_out_r;
    assign bus.dig_out = dig_out_r;

endmodule

// File: tb/tb_seg7_bcd_scan_counter.sv
// Directed, table-driven bench for seg7_bcd_scan_counter (DIGITS=4, TICK_DIV=4, SCAN_DIV=2).
module tb_seg7_bcd_scan_counter;

    logic clk;
    logic reset;

    seg7_bcd_scan_counter_if #(.DIGITS(4)) bus_if ();

    seg7_bcd_scan_counter #(
        .DIGITS   (4),
        .TICK_DIV (4),
        .SCAN_DIV (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        up_dn;
        logic        load;
        logic [15:0] load_val;
        logic [15:0] exp_count;
        logic        exp_wrap;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   passes = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic en, input logic up, input logic ld, input logic [15:0] lv,
                       input logic [15:0] ec, input logic ew, input int n);
        vec_t v;
        v = '{en, up, ld, lv, ec, ew};
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    // Sync to the start of a scan at digit 0, then check 10 cycles of selects and segments.
    task automatic scan_check(input logic [31:0] exp_dig, input string tag);
        logic [3:0] prev;
        logic [3:0] es;
        int         found;
        int         d;
        found = 0;
        prev  = bus_if.sel_out;
        for (int k = 0; k < 20 && found == 0; k++) begin
            step();
            if (prev == 4'b0111 && bus_if.sel_out == 4'b1110) found = 1;
            else prev = bus_if.sel_out;
        end
        chk({tag, "_sync"}, found, 1);
        if (found == 1) begin
            for (int c = 0; c < 10; c++) begin
                d  = (c / 2) % 4;
                es = 4'b0001 << d;
                es = ~es;
                chk({tag, "_sel"}, bus_if.sel_out, es);
                chk({tag, "_dig"}, bus_if.dig_out, exp_dig[8*d +: 8]);
                step();
            end
        end
    endtask

    initial begin
        int k;
        reset           = 1'b0;
        bus_if.en       = 1'b1;
        bus_if.up_dn    = 1'b1;
        bus_if.load     = 1'b0;
        bus_if.load_val = 16'h0000;
        bus_if.dp_mask  = 4'b0000;

        // Reset state
        step();
        chk("rst_count", bus_if.count, 16'h0000);
        chk("rst_wrap", bus_if.wrap, 1'b0);
        chk("rst_sel", bus_if.sel_out, 4'hF);
        chk("rst_dig", bus_if.dig_out, 8'hFF);

        // Free count up for 40 cycles: one step every 4 clocks, 0009 -> 0010 ripple
        reset = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (n == 1) begin
                chk("first_sel", bus_if.sel_out, 4'b1110);
                chk("first_dig", bus_if.dig_out, 8'hC0);
            end
            k = n / 4;
            chk("run_count", bus_if.count, ((k / 10) << 4) | (k % 10));
            chk("run_wrap", bus_if.wrap, 1'b0);
        end

        // Table: loads, saturation, wrap up/down, load priority, prescaler clear, en hold
        add(1, 1, 1, 16'h9998, 16'h9998, 0, 1);
        add(1, 1, 0, 16'h0000, 16'h9998, 0, 3);
        add(1, 1, 0, 16'h0000, 16'h9999, 0, 1);
        add(1, 1, 0, 16'h0000, 16'h9999, 0, 3);
        add(1, 1, 0, 16'h0000, 16'h0000, 1, 1);
        add(1, 1, 0, 16'h0000, 16'h0000, 0, 1);
        add(1, 0, 1, 16'h0000, 16'h0000, 0, 1);
        add(1, 0, 0, 16'h0000, 16'h0000, 0, 3);
        add(1, 0, 0, 16'h0000, 16'h9999, 1, 1);
        add(1, 0, 0, 16'h0000, 16'h9999, 0, 1);
        add(0, 0, 1, 16'hAB3F, 16'h9939, 0, 1);
        add(0, 1, 1, 16'h0009, 16'h0009, 0, 1);
        add(1, 1, 0, 16'h0000, 16'h0009, 0, 2);
        add(1, 1, 1, 16'h0042, 16'h0042, 0, 1);
        add(1, 1, 0, 16'h0000, 16'h0042, 0, 3);
        add(1, 1, 0, 16'h0000, 16'h0043, 0, 1);
        add(1, 1, 0, 16'h0000, 16'h0043, 0, 3);
        add(1, 1, 1, 16'h0100, 16'h0100, 0, 1);
        add(1, 1, 0, 16'h0000, 16'h0100, 0, 2);
        add(0, 1, 0, 16'h0000, 16'h0100, 0, 10);
        add(1, 1, 0, 16'h0000, 16'h0100, 0, 1);
        add(1, 1, 0, 16'h0000, 16'h0101, 0, 1);
        add(1, 0, 1, 16'h0100, 16'h0100, 0, 1);
        add(1, 0, 0, 16'h0000, 16'h0100, 0, 3);
        add(1, 0, 0, 16'h0000, 16'h0099, 0, 1);

        foreach (vecs[i]) begin
            bus_if.en       = vecs[i].en;
            bus_if.up_dn    = vecs[i].up_dn;
            bus_if.load     = vecs[i].load;
            bus_if.load_val = vecs[i].load_val;
            step();
            chk("vec_count", bus_if.count, vecs[i].exp_count);
            chk("vec_wrap", bus_if.wrap, vecs[i].exp_wrap);
        end

        // Scan sequence for 1234 with the dp lit on digit 2
        bus_if.en       = 1'b0;
        bus_if.load     = 1'b1;
        bus_if.load_val = 16'h1234;
        bus_if.dp_mask  = 4'b0100;
        step();
        bus_if.load = 1'b0;
        step();
        chk("scan_count", bus_if.count, 16'h1234);
        scan_check(32'hF924B099, "scan1234");

        // One-cycle reset in mid-scan, then digit 0 shows first
        step();
        reset = 1'b0;
        step();
        chk("midrst_sel", bus_if.sel_out, 4'hF);
        chk("midrst_dig", bus_if.dig_out, 8'hFF);
        chk("midrst_count", bus_if.count, 16'h0000);
        chk("midrst_wrap", bus_if.wrap, 1'b0);
        reset = 1'b1;
        step();
        chk("rel_sel", bus_if.sel_out, 4'b1110);
        chk("rel_dig", bus_if.dig_out, 8'hC0);

        // Leading zeros are decoded when blanking is not built in
        bus_if.load     = 1'b1;
        bus_if.load_val = 16'h0050;
        bus_if.dp_mask  = 4'b0000;
        step();
        bus_if.load = 1'b0;
        step();
        scan_check(32'hC0C092C0, "scan0050");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
